butterfly_seq: RTL and testbench

- Sequencer that drives the shared 4-way butterfly datapath of the 32-point radix-2 FFT.
- Fetch side: requests one group of 8 complex inputs and 4 twiddles from the data/twiddle memories.
- Compute side: steps the butterfly's 4:1 select through 4 slots, firing the matching capture enable on each.
- Write-back side: hands the 8 registered results to the write-back logic with a valid/ready handshake.
- Covers all LOG2N stages × N_POINTS/8 passes, then pulses done.

---
 rtl/butterfly_seq.sv | 129 ++++++++++++
 tb/tb_butterfly_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/butterfly_seq.sv
// Sequencer for the shared 4-way butterfly of a radix-2 FFT: operand fetch,
// four compute slots, and a valid/ready write-back for every stage/pass.
module butterfly_seq #(
   parameter int unsigned N_POINTS  = 32,
   parameter int unsigned LOG2N     = 5,
   parameter int unsigned TW_ADDR_W = 4,
   parameter int unsigned PASS_W    = 2
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 ld_ack,
   input  logic                 wb_ready,
   output logic [1:0]           sel,
   output logic                 en1,
   output logic                 en2,
   output logic                 en3,
   output logic                 en4,
   output logic                 ld_req,
   output logic [TW_ADDR_W-1:0] tw_addr1,
   output logic [TW_ADDR_W-1:0] tw_addr2,
   output logic [TW_ADDR_W-1:0] tw_addr3,
   output logic [TW_ADDR_W-1:0] tw_addr4,
   output logic [2:0]           stage,
   output logic [PASS_W-1:0]    pass,
   output logic                 wb_valid,
   output logic                 busy,
   output logic                 done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_CALC   = 3'd2;
   localparam logic [2:0] S_UNLOAD = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(N_POINTS / 8 - 1);
   localparam logic [2:0]        LAST_STAGE = 3'(LOG2N - 1);

   logic [2:0]        state_q, state_d;
   logic [2:0]        stage_q, stage_d;
   logic [PASS_W-1:0] pass_q,  pass_d;
   logic [1:0]        slot_q,  slot_d;

   always_ff @(posedge clk_50 or posedge rst_n) begin
      if (rst_n) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         pass_q  <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         pass_q  <= pass_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      pass_d  = pass_q;
      slot_d  = slot_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               stage_d = '0;
               pass_d  = '0;
            end
         end
         S_LOAD: begin
            if (ld_ack) begin
               state_d = S_CALC;
               slot_d  = '0;
            end
         end
         S_CALC: begin
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) state_d = S_UNLOAD;
         end
         S_UNLOAD: begin
            if (wb_ready) begin
               if (stage_q == LAST_STAGE && pass_q == LAST_PASS) begin
                  state_d = S_DONE;
               end else begin
                  // pass count is a power of two, so it wraps to 0 by itself
                  pass_d  = pass_q + 1'b1;
                  if (pass_q == LAST_PASS) stage_d = stage_q + 3'd1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Twiddle index: (b mod 2^stage) << (LOG2N-1-stage), b = 4*pass + slot
   function automatic logic [TW_ADDR_W-1:0] tw_calc(input logic [2:0]        stg,
                                                    input logic [PASS_W-1:0] ps,
                                                    input logic [1:0]        j);
      logic [31:0] b;
      logic [31:0] m;
      b = 32'({ps, j});
      m = b & ((32'd1 << stg) - 32'd1);
      m = m << (32'(LOG2N - 1) - 32'(stg));
      return m[TW_ADDR_W-1:0];
   endfunction

   always_comb begin
      sel      = (state_q == S_CALC) ? slot_q : '0;
      en1      = (state_q == S_CALC) && (slot_q == 2'd0);
      en2      = (state_q == S_CALC) && (slot_q == 2'd1);
      en3      = (state_q == S_CALC) && (slot_q == 2'd2);
      en4      = (state_q == S_CALC) && (slot_q == 2'd3);
      ld_req   = (state_q == S_LOAD);
      wb_valid = (state_q == S_UNLOAD);
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      stage    = stage_q;
      pass     = pass_q;
      tw_addr1 = tw_calc(stage_q, pass_q, 2'd0);
      tw_addr2 = tw_calc(stage_q, pass_q, 2'd1);
      tw_addr3 = tw_calc(stage_q, pass_q, 2'd2);
      tw_addr4 = tw_calc(stage_q, pass_q, 2'd3);
   end

endmodule

// File: tb/tb_butterfly_seq.sv
// Scoreboard bench for butterfly_seq: expected stage/pass/twiddles per
// write-back are queued by stimulus and popped by a handshake monitor.
module tb_butterfly_seq;

   logic       clk_50 = 1'b0;
   logic       rst_n, start, ld_ack, wb_ready;
   logic [1:0] sel;
   logic       en1, en2, en3, en4, ld_req, wb_valid, busy, done;
   logic [3:0] tw_addr1, tw_addr2, tw_addr3, tw_addr4;
   logic [2:0] stage;
   logic [1:0] pass;

   butterfly_seq #(.N_POINTS(32), .LOG2N(5), .TW_ADDR_W(4), .PASS_W(2)) dut (
      .clk_50(clk_50), .rst_n(rst_n), .start(start), .ld_ack(ld_ack),
      .wb_ready(wb_ready), .sel(sel), .en1(en1), .en2(en2), .en3(en3),
      .en4(en4), .ld_req(ld_req), .tw_addr1(tw_addr1), .tw_addr2(tw_addr2),
      .tw_addr3(tw_addr3), .tw_addr4(tw_addr4), .stage(stage), .pass(pass),
      .wb_valid(wb_valid), .busy(busy), .done(done)
   );

   always #5 clk_50 = ~clk_50;

   typedef struct {
      logic [2:0]  stg;
      logic [1:0]  ps;
      logic [15:0] tw;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] tw_tab [0:19];
   logic [7:0]  pat    [0:5];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] tw_now();
      return {tw_addr1, tw_addr2, tw_addr3, tw_addr4};
   endfunction

   task automatic push_first(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.stg = 3'(i / 4);
         e.ps  = 2'(i % 4);
         e.tw  = tw_tab[i];
         sbq.push_back(e);
      end
   endtask

   // Monitor: every accepted write-back must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_50);
         if (!rst_n && wb_valid && wb_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("sb_stage", 32'(stage), 32'(e.stg));
               chk("sb_pass", 32'(pass), 32'(e.ps));
               chk("sb_twiddle", 32'(tw_now()), 32'(e.tw));
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk_50) start = 1'b1;
      @(posedge clk_50);
      #1 start = 1'b0;
   endtask

   task automatic run_full(input bit glitch);
      int done_cyc = 0, done_cnt = 0, wbv_cnt = 0, busy_cnt = 0, bad_en = 0;
      logic [3:0] env;
      push_first(20);
      ld_ack   = 1'b1;
      wb_ready = 1'b1;
      pulse_start();
      for (int n = 1; n <= 125; n++) begin
         @(negedge clk_50);
         env = {en4, en3, en2, en1};
         if (n == 1) chk("first_stage_pass", 32'({stage, pass}), 32'd0);
         if (n <= 6) chk("pass_pattern", 32'({ld_req, wb_valid, sel, env}), 32'(pat[n-1]));
         if ($countones(env) > 1 || (env != 4'd0 && env != (4'd1 << sel)) ||
             (env == 4'd0 && sel != 2'd0)) bad_en++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = n;
         end
         if (wb_valid) wbv_cnt++;
         if (busy) busy_cnt++;
         if (n == 122) chk("idle_after_done", 32'(busy), 32'd0);
         if (glitch && (n == 3 || n == 121)) start = 1'b1;
         else start = 1'b0;
      end
      chk("done_cycle", 32'(done_cyc), 32'd121);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("wb_valid_count", 32'(wbv_cnt), 32'd20);
      chk("busy_cycles", 32'(busy_cnt), 32'd121);
      chk("enable_onehot", 32'(bad_en), 32'd0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
   endtask

   task automatic run_bp();
      bit seen = 1'b0;
      push_first(20);
      ld_ack   = 1'b0;
      wb_ready = 1'b0;
      pulse_start();
      repeat (3) begin
         @(negedge clk_50);
         chk("bp_load_hold", 32'({ld_req, wb_valid, en4, en3, en2, en1, stage, pass}),
             32'(12'b1_0_0000_000_00));
      end
      @(posedge clk_50);
      #1 ld_ack = 1'b1;
      @(negedge clk_50);
      chk("bp_load_ack_cycle", 32'({ld_req, sel}), 32'(3'b1_00));
      repeat (4) @(negedge clk_50);
      repeat (5) begin
         @(negedge clk_50);
         chk("bp_unload_hold", 32'({ld_req, wb_valid, en4, en3, en2, en1, stage, pass}),
             32'(12'b0_1_0000_000_00));
      end
      @(posedge clk_50);
      #1 wb_ready = 1'b1;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk_50);
         if (done) seen = 1'b1;
      end
      chk("bp_done_reached", 32'(seen), 32'd1);
      @(negedge clk_50);
      chk("bp_sb_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit = 1'b0;
      tw_tab = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0808, 16'h0808, 16'h0808, 16'h0808,
                 16'h048C, 16'h048C, 16'h048C, 16'h048C,
                 16'h0246, 16'h8ACE, 16'h0246, 16'h8ACE,
                 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      pat = '{8'h80, 8'h01, 8'h12, 8'h24, 8'h38, 8'h40};
      rst_n = 1'b1; start = 1'b0; ld_ack = 1'b0; wb_ready = 1'b0;
      repeat (2) @(negedge clk_50);
      chk("reset_state", 32'({busy, done, ld_req, wb_valid, sel, en4, en3, en2, en1,
                              stage, pass, tw_now()}), 32'd0);
      rst_n = 1'b0;

      // Async reset in the middle of a CALC slot of a later pass
      push_first(1);
      ld_ack   = 1'b1;
      wb_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge clk_50);
         if (pass == 2'd1 && sel == 2'd2 && en3) hit = 1'b1;
      end
      chk("reach_calc_slot2", 32'(hit), 32'd1);
      #2 rst_n = 1'b1;
      #1 chk("async_reset_outputs", 32'({busy, done, ld_req, wb_valid, sel, en4, en3, en2, en1,
                                         stage, pass}), 32'd0);
      @(negedge clk_50) rst_n = 1'b0;
      chk("partial_sb_drained", 32'(sbq.size()), 32'd0);

      run_full(1'b0);
      run_bp();
      run_full(1'b1);
      run_full(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
